// File: rtl/alu.sv
// Registered 32-bit RV32I integer ALU.
// A single shared adder serves ADD, SUB and the SLT/SLTU compares.
// Result and {N, Z, C, V} flags are captured one clock after the operands arrive.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  funct7,
  input  logic [2:0]  funct3,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic [3:0]  alu_flags
);

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  logic        do_sub;
  logic [31:0] b_eff;
  logic [32:0] sum_full;
  logic [31:0] sum;
  logic        carry;
  logic        ovf;
  logic        lt_signed;
  logic        lt_unsigned;
  logic [4:0]  shamt;
  logic [31:0] result_d;
  logic [3:0]  flags_d;
  logic [31:0] result_q;
  logic [3:0]  flags_q;

  // Only funct7[5] is decoded; the remaining bits are deliberately ignored.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Shared adder: A+B only for ADD, A+~B+1 for everything else.
  always_comb begin
    do_sub      = !((funct3 == F3_ADDSUB) && !funct7[5]);
    b_eff       = do_sub ? ~B : B;
    sum_full    = {1'b0, A} + {1'b0, b_eff} + {32'd0, do_sub};
    sum         = sum_full[31:0];
    carry       = sum_full[32];
    ovf         = (A[31] == b_eff[31]) && (sum[31] != A[31]);
    // Signed less-than is N xor V of A-B; unsigned less-than is a borrow.
    lt_signed   = sum[31] ^ ovf;
    lt_unsigned = ~carry;
    shamt       = B[4:0];
  end

  // Operation select and flag formation.
  always_comb begin
    result_d = 32'h0;
    unique case (funct3)
      F3_ADDSUB: result_d = sum;
      F3_SLL:    result_d = A << shamt;
      F3_SLT:    result_d = {31'd0, lt_signed};
      F3_SLTU:   result_d = {31'd0, lt_unsigned};
      F3_XOR:    result_d = A ^ B;
      F3_SR:     result_d = funct7[5] ? 32'($signed(A) >>> shamt) : (A >> shamt);
      F3_OR:     result_d = A | B;
      F3_AND:    result_d = A & B;
      default:   result_d = 32'h0;
    endcase
    flags_d = {result_d[31], (result_d == 32'h0), carry, ovf};
  end

  // Output registers; reset clears them immediately and discards in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'h0;
      flags_q  <= 4'b0000;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign result    = result_q;
  assign alu_flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered RV32I ALU.
// Expected {result, flags} is pushed when an operation is driven and
// popped/compared one edge later when the DUT registers it.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] result;
  logic [3:0]  alu_flags;

  logic [35:0] exp_q[$];
  int checks;
  int errors;

  localparam logic [6:0] F7_0 = 7'b0000000;
  localparam logic [6:0] F7_1 = 7'b0100000;

  alu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .funct7    (funct7),
    .funct3    (funct3),
    .A         (A),
    .B         (B),
    .result    (result),
    .alu_flags (alu_flags)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: wide signed/unsigned arithmetic, not an adder replica.
  function automatic logic [35:0] exp_model(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] b);
    logic        sub;
    logic [31:0] r;
    logic        c;
    logic        v;
    longint      sa;
    longint      sb;
    longint      s;
    logic [32:0] u;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sub = !(f3 == 3'b000 && !f7[5]);
    if (!sub) begin
      u = {1'b0, a} + {1'b0, b};
      c = u[32];
      s = sa + sb;
    end else begin
      c = (a >= b);
      s = sa - sb;
    end
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    case (f3)
      3'b000:  r = sub ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = (sa < sb) ? 32'd1 : 32'd0;
      3'b011:  r = (a < b) ? 32'd1 : 32'd0;
      3'b100:  r = a ^ b;
      3'b101:  r = f7[5] ? 32'(sa >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  // Driver: apply an operation at the falling edge and record its expectation.
  task automatic drive_op(input logic [6:0] f7, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct7 = f7;
    funct3 = f3;
    A      = a;
    B      = b;
    exp_q.push_back(exp_model(f7, f3, a, b));
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    funct7 = 'x;
    funct3 = 'x;
    A      = 'x;
    B      = 'x;
    #3;
    checks++;
    if (result !== 32'h0 || alu_flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: result=%h flags=%b, want 0/0000", result, alu_flags);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h0 || alu_flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_x_inputs: result=%h flags=%b, want 0/0000", result, alu_flags);
    end
    @(negedge clk);
    funct7 = F7_0;
    funct3 = 3'b000;
    A      = 32'd0;
    B      = 32'd0;
    rst_n  = 1'b1;
  endtask

  task automatic test_arith;
    logic [6:0]  f7_t[4]  = '{F7_0, F7_1, F7_1, F7_0};
    logic [31:0] a_t[4]   = '{32'd20, 32'd20, 32'd5, 32'h7FFFFFFF};
    logic [31:0] b_t[4]   = '{32'd30, 32'd30, 32'd5, 32'd1};
    logic [31:0] r_t[4]   = '{32'd50, 32'hFFFFFFF6, 32'h0, 32'h80000000};
    logic [3:0]  fl_t[4]  = '{4'b0000, 4'b1000, 4'b0110, 4'b1001};
    logic [35:0] e;
    for (int i = 0; i < 4; i++) begin
      drive_op(f7_t[i], 3'b000, a_t[i], b_t[i]);
      @(posedge clk);
      #1;
      checks++;
      if (result !== r_t[i] || alu_flags !== fl_t[i]) begin
        errors++;
        $display("FAIL arith_%0d: result=%h flags=%b, want %h/%b", i, result, alu_flags, r_t[i], fl_t[i]);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL arith_sb_%0d: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({result, alu_flags} !== e) begin
          errors++;
          $display("FAIL arith_sb_%0d: got %h/%b, want %h/%b", i, result, alu_flags, e[35:4], e[3:0]);
        end
      end
    end
  endtask

  task automatic test_shift;
    logic [6:0]  f7_t[6] = '{F7_0, F7_0, F7_1, F7_1, F7_0, 7'b1011111};
    logic [2:0]  f3_t[6] = '{3'b001, 3'b101, 3'b101, 3'b101, 3'b001, 3'b101};
    logic [31:0] a_t[6]  = '{32'h72452813, 32'h72452813, 32'h72452813, 32'hF0000000,
                             32'h72452813, 32'hF0000000};
    logic [31:0] b_t[6]  = '{32'd4, 32'd4, 32'd4, 32'd1, 32'h00000024, 32'hFFFFFFE4};
    logic [31:0] r_t[6]  = '{32'h24528130, 32'h07245281, 32'h07245281, 32'hF8000000,
                             32'h24528130, 32'h0F000000};
    logic [35:0] e;
    for (int i = 0; i < 6; i++) begin
      drive_op(f7_t[i], f3_t[i], a_t[i], b_t[i]);
      @(posedge clk);
      #1;
      checks++;
      if (result !== r_t[i]) begin
        errors++;
        $display("FAIL shift_%0d: result=%h, want %h", i, result, r_t[i]);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL shift_sb_%0d: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({result, alu_flags} !== e) begin
          errors++;
          $display("FAIL shift_sb_%0d: got %h/%b, want %h/%b", i, result, alu_flags, e[35:4], e[3:0]);
        end
      end
    end
  endtask

  task automatic test_compare_logic;
    logic [6:0]  f7_t[8] = '{F7_0, F7_0, F7_0, F7_1, F7_0, F7_0, F7_0, F7_1};
    logic [2:0]  f3_t[8] = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b100, 3'b110, 3'b111, 3'b111};
    logic [31:0] a_t[8]  = '{32'hFFFFFFFC, 32'd3, 32'd3, 32'hFFFFFFFC, 32'hF0F0F0F0,
                             32'hF0FFF0F0, 32'hF0FFF0F0, 32'h0000FFFF};
    logic [31:0] b_t[8]  = '{32'd3, 32'hFFFFFFFC, 32'd4, 32'd3, 32'h00FFFF00,
                             32'hFF0000FF, 32'hFF0000FF, 32'hFFFF0000};
    logic [31:0] r_t[8]  = '{32'd1, 32'd0, 32'd1, 32'd0, 32'hF00F0FF0,
                             32'hFFFFF0FF, 32'hF00000F0, 32'h0};
    logic [35:0] e;
    for (int i = 0; i < 8; i++) begin
      drive_op(f7_t[i], f3_t[i], a_t[i], b_t[i]);
      @(posedge clk);
      #1;
      checks++;
      if (result !== r_t[i]) begin
        errors++;
        $display("FAIL cmp_logic_%0d: result=%h, want %h", i, result, r_t[i]);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cmp_logic_sb_%0d: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({result, alu_flags} !== e) begin
          errors++;
          $display("FAIL cmp_logic_sb_%0d: got %h/%b, want %h/%b", i, result, alu_flags, e[35:4], e[3:0]);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    logic [35:0] e;
    drive_op(F7_0, 3'b000, 32'd20, 32'd30);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL areset_pre: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (result !== 32'd50 || {result, alu_flags} !== e) begin
        errors++;
        $display("FAIL areset_pre: got %h/%b, want %h/%b", result, alu_flags, e[35:4], e[3:0]);
      end
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 32'h0 || alu_flags !== 4'b0000) begin
      errors++;
      $display("FAIL areset_immediate: result=%h flags=%b, want 0/0000", result, alu_flags);
    end
    A = 'x;
    B = 'x;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 32'h0 || alu_flags !== 4'b0000) begin
      errors++;
      $display("FAIL areset_hold: result=%h flags=%b, want 0/0000", result, alu_flags);
    end
    drive_op(F7_0, 3'b000, 32'd20, 32'd30);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (result !== 32'h0 || alu_flags !== 4'b0000) begin
      errors++;
      $display("FAIL areset_release: result=%h flags=%b, want 0/0000", result, alu_flags);
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL areset_first_capture: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      if (result !== 32'd50 || {result, alu_flags} !== e) begin
        errors++;
        $display("FAIL areset_first_capture: got %h/%b, want %h/%b", result, alu_flags, e[35:4], e[3:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] edge_t[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000001F};
    logic [31:0] a;
    logic [31:0] b;
    logic [35:0] e;
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 3) == 0) ? edge_t[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_t[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      drive_op(7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), a, b);
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_%0d: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        if ({result, alu_flags} !== e) begin
          errors++;
          $display("FAIL b2b_%0d: f7=%b f3=%b A=%h B=%h got %h/%b, want %h/%b",
                   i, funct7, funct3, A, B, result, alu_flags, e[35:4], e[3:0]);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_arith();
    test_shift();
    test_compare_logic();
    test_async_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
